// File: rtl/fnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnn_pkg
// Description : Shared types and default sizing for the FNN layer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fnn_pkg;

  // Weight loader control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  // Default layer sizing
  localparam int NUM_WEIGHT = 30;
  localparam int NUM_NEURON = 4;
  localparam int DATA_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/weight_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader_if
// Description : Weight stream in, weight-memory write port out, plus the
//               load control/status strobes of the weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_loader_if #(
  parameter int DATA_WIDTH = fnn_pkg::DATA_WIDTH,
  parameter int NUM_NEURON = fnn_pkg::NUM_NEURON,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic [NUM_NEURON-1:0] wen;
  logic [ADDR_WIDTH-1:0] wadd;
  logic [DATA_WIDTH-1:0] win;
  logic                  busy;
  logic                  done;

  // Loader side: consumes the stream, drives the memory write port
  modport master (
    input  start, s_valid, s_data,
    output s_ready, wen, wadd, win, busy, done
  );

  // Host / memory side
  modport slave (
    output start, s_valid, s_data,
    input  s_ready, wen, wadd, win, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader
// Description : Streams weights into the per-neuron weight memories of one
//               layer in neuron-major order, pulsing done when all are full.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_loader #(
  parameter int NUM_WEIGHT   = fnn_pkg::NUM_WEIGHT,
  parameter int NUM_NEURON   = fnn_pkg::NUM_NEURON,
  parameter int DATA_WIDTH   = fnn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1,
  parameter int NEURON_WIDTH = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  weight_loader_if.master bus
);
  import fnn_pkg::loader_state_t;
  import fnn_pkg::IDLE;
  import fnn_pkg::LOAD;
  import fnn_pkg::DONE;

  localparam logic [ADDR_WIDTH-1:0]   C_LAST_ADDR   = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic [NEURON_WIDTH-1:0] C_LAST_NEURON = NEURON_WIDTH'(NUM_NEURON - 1);

  loader_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_cnt_q, addr_cnt_d;
  logic [NEURON_WIDTH-1:0] neu_cnt_q, neu_cnt_d;
  logic [NUM_NEURON-1:0]   wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   wadd_q, wadd_d;
  logic [DATA_WIDTH-1:0]   win_q, win_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic w_ready;
  logic w_accept;
  logic w_last_addr;
  logic w_last_neuron;

  // Ready is a pure state decode so there is no path from s_valid to s_ready
  assign w_ready       = (state_q == LOAD);
  assign w_accept      = bus.s_valid & w_ready;
  assign w_last_addr   = (addr_cnt_q == C_LAST_ADDR);
  assign w_last_neuron = (neu_cnt_q == C_LAST_NEURON);

  assign bus.s_ready = w_ready;
  assign bus.wen     = wen_q;
  assign bus.wadd    = wadd_q;
  assign bus.win     = win_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  // Next-state, counter and write-port decode
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    neu_cnt_d  = neu_cnt_q;
    wen_d      = '0;
    wadd_d     = wadd_q;
    win_d      = win_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = LOAD;
          addr_cnt_d = '0;
          neu_cnt_d  = '0;
        end
      end
      LOAD: begin
        if (w_accept) begin
          wen_d[neu_cnt_q] = 1'b1;
          wadd_d           = addr_cnt_q;
          win_d            = bus.s_data;
          if (w_last_addr) begin
            addr_cnt_d = '0;
            neu_cnt_d  = w_last_neuron ? '0 : neu_cnt_q + 1'b1;
            if (w_last_neuron) begin
              state_d = DONE;
            end
          end else begin
            addr_cnt_d = addr_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status strobes are registered from the next state so they line up with it
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, counters and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_cnt_q <= '0;
      neu_cnt_q  <= '0;
      wen_q      <= '0;
      wadd_q     <= '0;
      win_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      neu_cnt_q  <= neu_cnt_d;
      wen_q      <= wen_d;
      wadd_q     <= wadd_d;
      win_q      <= win_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_loader
// Description : Directed self-checking bench for weight_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_loader;
  localparam int NW = 30;
  localparam int NN = 4;
  localparam int DW = 16;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic clr_mem;

  always #5 clk = ~clk;

  weight_loader_if #(.DATA_WIDTH(DW), .NUM_NEURON(NN), .ADDR_WIDTH(AW)) bus ();

  weight_loader #(
    .NUM_WEIGHT  (NW),
    .NUM_NEURON  (NN),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NEURON_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Behavioural weight memories fed by the write port
  logic [DW-1:0] mem [NN][NW];
  always @(posedge clk) begin
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < NW; a++) begin
        if (clr_mem) mem[n][a] <= 16'hFFFF;
        else if (bus.wen[n] && (int'(bus.wadd) == a)) mem[n][a] <= bus.win;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Write port expected in the cycle after beat k is accepted
  task automatic expect_write(input string tag, input int k, input logic [DW-1:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << (k / NW);
    check({tag, "_wen"},  32'(bus.wen),  32'(oh));
    check({tag, "_wadd"}, 32'(bus.wadd), 32'(k % NW));
    check({tag, "_win"},  32'(bus.win),  32'(d));
  endtask

  task automatic check_mem(input string tag, input logic [DW-1:0] base);
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < NW; a++)
        check(tag, 32'(mem[n][a]), 32'(base + DW'(n * NW + a)));
  endtask

  initial begin
    int cs, cd, k, guard;
    logic v;

    // Reset values, and s_valid in IDLE is not accepted
    rst = 1'b1; clr_mem = 1'b1;
    bus.start = 1'b0; bus.s_valid = 1'b1; bus.s_data = 16'h5555;
    repeat (3) tick();
    check("rst_s_ready", 32'(bus.s_ready), 0);
    check("rst_wen",     32'(bus.wen),     0);
    check("rst_wadd",    32'(bus.wadd),    0);
    check("rst_win",     32'(bus.win),     0);
    check("rst_busy",    32'(bus.busy),    0);
    check("rst_done",    32'(bus.done),    0);
    rst = 1'b0; clr_mem = 1'b0;
    tick();
    check("idle_valid_wen",     32'(bus.wen),     0);
    check("idle_valid_s_ready", 32'(bus.s_ready), 0);
    check("idle_valid_busy",    32'(bus.busy),    0);
    bus.s_valid = 1'b0;

    // Full back-to-back load, data = k
    cs = cyc;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("full_s_ready", 32'(bus.s_ready), 1);
    check("full_busy",    32'(bus.busy),    1);
    cd = -1;
    for (int b = 0; b < 120; b++) begin
      bus.s_valid = 1'b1; bus.s_data = DW'(b);
      tick();
      if (b == 0)   expect_write("full_b0",   b, DW'(b));
      if (b == 29)  expect_write("full_b29",  b, DW'(b));
      if (b == 30)  expect_write("full_b30",  b, DW'(b));
      if (b == 118) check("full_done_early", 32'(bus.done), 0);
      if (b == 119) begin
        expect_write("full_b119", b, 16'h0077);
        check("full_done",         32'(bus.done),    1);
        check("full_done_s_ready", 32'(bus.s_ready), 0);
        cd = cyc;
      end
    end
    bus.s_valid = 1'b0;
    check("full_done_latency", 32'(cd - cs + 1), 122);
    tick();
    check("full_done_pulse", 32'(bus.done),    0);
    check("full_end_busy",   32'(bus.busy),    0);
    check("full_end_ready",  32'(bus.s_ready), 0);
    check("full_end_wen",    32'(bus.wen),     0);
    check_mem("full_mem", 16'h0000);

    // Bubbled stream with random valid gaps
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    k = 0; guard = 0;
    while (k < 120 && guard < 2000) begin
      v = 1'($urandom_range(0, 1));
      bus.s_valid = v; bus.s_data = 16'h1000 + DW'(k);
      tick();
      guard++;
      if (v) begin
        expect_write("bub", k, 16'h1000 + DW'(k));
        k++;
      end else begin
        check("bub_gap_wen", 32'(bus.wen), 0);
      end
    end
    if (k < 120) check("bub_timeout", 32'(k), 120);
    bus.s_valid = 1'b0;
    check("bub_done", 32'(bus.done), 1);
    tick();
    check("bub_end_busy", 32'(bus.busy), 0);
    check_mem("bub_mem", 16'h1000);

    // Start pulses during LOAD are ignored
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int b = 0; b < 120; b++) begin
      bus.s_valid = 1'b1; bus.s_data = 16'h2000 + DW'(b);
      bus.start = (b == 10 || b == 60);
      tick();
      bus.start = 1'b0;
      if (b == 10 || b == 11 || b == 60 || b == 61)
        expect_write("ign", b, 16'h2000 + DW'(b));
      if (b == 119) begin
        expect_write("ign_last", b, 16'h2000 + DW'(b));
        check("ign_done", 32'(bus.done), 1);
      end
    end
    bus.s_valid = 1'b0;
    tick();
    check("ign_end_busy", 32'(bus.busy), 0);
    check_mem("ign_mem", 16'h2000);

    // Reset after beat 45, then restart from neuron 0 address 0
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int b = 0; b <= 45; b++) begin
      bus.s_valid = 1'b1; bus.s_data = 16'h3000 + DW'(b);
      tick();
    end
    bus.s_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_wen",     32'(bus.wen),     0);
    check("mid_rst_busy",    32'(bus.busy),    0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("restart_s_ready", 32'(bus.s_ready), 1);
    bus.s_valid = 1'b1; bus.s_data = 16'h4000;
    tick();
    expect_write("restart", 0, 16'h4000);
    bus.s_valid = 1'b0;
    tick();
    check("restart_mem00",  32'(mem[0][0]),  32'h4000);
    check("kept_mem_1_15",  32'(mem[1][15]), 32'h302D);
    check("kept_mem_2_0",   32'(mem[2][0]),  32'h203C);

    // Reset and start together: reset wins, stays IDLE
    rst = 1'b1; tick();
    bus.start = 1'b1; tick();
    rst = 1'b0; bus.start = 1'b0;
    check("collide_s_ready", 32'(bus.s_ready), 0);
    check("collide_busy",    32'(bus.busy),    0);
    tick();
    check("collide_idle_s_ready", 32'(bus.s_ready), 0);
    check("collide_idle_busy",    32'(bus.busy),    0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/weight_loader.md
# weight_loader

Streaming writer for the per-neuron weight memories of one FNN layer. Accepts a valid/ready stream of weights after a `start` pulse and drives the write ports (`wen`, `wadd`, `win`) of `numNeuron` weight memories in neuron-major order. It pulses `done` when every memory is full. It sits between the host/DMA weight stream and the layer's weight RAMs, and is the write-side counterpart of the memories' registered read port.

## Interface
- `numWeight`, 30: weights per neuron memory (memory depth)
- `numNeuron`, 4: neuron memories in the layer
- `dataWidth`, 16: weight word width (Q-format as in the datapath, passed through untouched)
- `addressWidth`, `$clog2(numWeight)`: memory address width
- `neuronWidth`, `$clog2(numNeuron)` (min 1): neuron index width

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a full layer load
- `s_valid`  in  1  input weight valid
- `s_data`  in  dataWidth  input weight
- `s_ready`  out  1  loader accepts a beat this cycle
- `wen`  out  numNeuron  one-hot write enable, bit n targets neuron n memory
- `wadd`  out  addressWidth  write address, common to all memories
- `win`  out  dataWidth  write data, common to all memories
- `busy`  out  1  load in progress (state LOAD or DONE)
- `done`  out  1  one-cycle pulse, load complete

## Operation
- FSM states:
  - IDLE: `s_ready`=0. `start`=1 moves to LOAD and clears the counters.
  - LOAD: `s_ready`=1. The accepted beat (`s_valid`&`s_ready`) that is the last word of the last neuron moves the FSM to DONE.
  - DONE: one cycle. `done`=1, `s_ready`=0. Unconditionally returns to IDLE.
- Counters:
  - `addr_cnt` (0..numWeight-1) increments on each accepted beat.
  - When `addr_cnt`=numWeight-1 is accepted, `addr_cnt` wraps to 0 and `neu_cnt` (0..numNeuron-1) increments.
  - Beat k writes neuron k/numWeight, address k mod numWeight. Total beats = numWeight*numNeuron.
- Write port is registered. For an accepted beat:
  - `win`←`s_data`, `wadd`←`addr_cnt`, `wen`←one-hot(`neu_cnt`) on the next edge.
  - Otherwise `wen`←0 and `wadd`/`win` hold their previous values.
- `start` in LOAD or DONE is ignored; no restart or re-arm.
- `s_valid` with no `start` (IDLE) is not accepted. The beat stays pending upstream.
- `s_data` is sampled only on accept and is don't-care otherwise.
- Gaps (`s_valid`=0) in LOAD stall the counters indefinitely; there is no timeout.
- Reset during LOAD:
  - FSM returns to IDLE, counters reset to 0, `wen`=0 from the next edge.
  - Already-written words remain in memory; no clearing is performed.
- `rst` and `start` in the same cycle: reset wins.

## Timing
- Reset values: `s_ready`=0, `wen`=0, `wadd`=0, `win`=0, `busy`=0, `done`=0, state IDLE.
- `start` at edge t (sampled high): LOAD and `s_ready`=1 from cycle t+1.
- Accept-to-write latency is 1 cycle. A beat accepted at edge t appears on `wen`/`wadd`/`win` during cycle t+1, and the memory captures it at edge t+1.
- Last beat accepted at edge t:
  - DONE in cycle t+1.
  - `done`=1 and the final `wen` are both high in cycle t+1 (same cycle).
  - `s_ready`=0 from cycle t+1.
  - IDLE at t+2.
- Peak throughput: one weight per cycle. Minimum load = numWeight*numNeuron + 2 cycles from `start`.
- `s_ready` is a pure decode of the registered state, with no combinational path from `s_valid`.
- `busy` = (state≠IDLE), registered.

## Structure
- Shared package `fnn_pkg`:
  - `loader_state_t` enum {IDLE, LOAD, DONE}.
  - Default constants `NUM_WEIGHT`, `NUM_NEURON`, `DATA_WIDTH`.
- No sub-module required: one FSM, two counters and an output register stage.
- In the layer top, `wen[n]` connects to the `wen` of neuron n's weight memory. `wadd`/`win` fan out to all memories.

## Test plan
All scenarios use the defaults (numWeight=30, numNeuron=4).
- **Reset values:** `rst`=1 for 3 cycles → all outputs 0, `s_ready`=0. `s_valid`=1 in IDLE → no `wen`.
- **Full back-to-back load:** `start`, then 120 beats with data 16'h0000+k and `s_valid` held 1.
  - Beat 0 → `wen`=4'b0001, `wadd`=0.
  - Beat 29 → `wen`=4'b0001, `wadd`=29.
  - Beat 30 → `wen`=4'b0010, `wadd`=0.
  - Beat 119 → `wen`=4'b1000, `wadd`=29, `win`=16'h0077, with `done`=1 in that same cycle.
  - `done` arrives 122 cycles after `start`.
  - Read-back of each memory matches.
- **Bubbled stream:** `s_valid` toggling with a random 50% duty → exactly 120 `wen` pulses, in order. `wen`=0 on cycles with no accept. `done` follows the last accept by 1 cycle.
- **Ignored start:** `start` pulses at beats 10 and 60 → counters unaffected and the load completes normally.
- **Reset mid-load:** `rst` after beat 45 → `wen`=0 and `busy`=0 the next cycle. A new `start` then rewrites from neuron 0, address 0.
- **Reset vs start collision:** `rst`=1 and `start`=1 in the same cycle → remains IDLE and `s_ready`=0.
